modinv_helper_precalc_param: RTL

Parametrised word-serial precalculation engine for the modular inverter. It is the next generation of the inverter's precalc helper, generalised in word width and operand length. For operands A and B it produces, in two buffer passes, 2A, 2B, A+B, A−B and B−A, then A/2, B/2, (A−B)/2 and (B−A)/2, with selectable logical or arithmetic halving of the differences. It also exports carry, borrow and equality flags and runs under a start/busy/done handshake.

---
 rtl/modinv_helper_precalc_param_pkg.sv | 30 +++
 rtl/modinv_precalc_addsub_word.sv | 44 ++++
 rtl/modinv_helper_precalc_param.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/modinv_helper_precalc_param_pkg.sv
// Shared definitions for the parametrised modular-inverse precalc helper:
// FSM state encodings, halving-mode constants and a constant clog2.
package modinv_helper_precalc_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

    // Smallest r such that 2^r >= v (valid for v <= 2^31).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (p < v) begin
                r = i + 1;
                p = p << 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/modinv_precalc_addsub_word.sv
// One word slice of a multi-word adder or subtractor. The carry/borrow
// between words is held in a register so the chain advances one word per
// enabled cycle; clr_i restarts the chain with a zero input.
module modinv_precalc_addsub_word #(
    parameter int unsigned WORD_W = 32,
    parameter bit          SUB    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [WORD_W-1:0] res_o,
    output logic              cb_o
);

    logic              cb_q;
    logic [WORD_W:0]   full;

    // Word result; the extra MSB is the carry-out (add) or borrow-out (sub).
    always_comb begin
        if (SUB) begin
            full = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, cb_q};
        end else begin
            full = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cb_q};
        end
    end

    assign res_o = full[WORD_W-1:0];
    assign cb_o  = full[WORD_W];

    // Chain register: cleared at operation start, advanced on each word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cb_q <= 1'b0;
        end else if (clr_i) begin
            cb_q <= 1'b0;
        end else if (en_i) begin
            cb_q <= cb_o;
        end
    end

endmodule

// File: rtl/modinv_helper_precalc_param.sv
// Word-serial precalc engine: pass 1 (ascending) produces 2A, 2B, A+B, A-B,
// B-A and the carry/borrow/equality flags; pass 2 (descending) produces the
// halves of A, B, A-B and B-A using the readback of the difference buffers.
module modinv_helper_precalc_param
    import modinv_helper_precalc_param_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 9,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shift_mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] a_din,
    input  logic [WORD_W-1:0] b_din,
    input  logic [WORD_W-1:0] amb_din,
    input  logic [WORD_W-1:0] bma_din,
    output logic [ADDR_W-1:0] p1_wr_addr,
    output logic              p1_wren,
    output logic [WORD_W-1:0] a_dbl_dout,
    output logic [WORD_W-1:0] b_dbl_dout,
    output logic [WORD_W-1:0] apb_dout,
    output logic [WORD_W-1:0] amb_dout,
    output logic [WORD_W-1:0] bma_dout,
    output logic [ADDR_W-1:0] p2_wr_addr,
    output logic              p2_wren,
    output logic [WORD_W-1:0] a_half_dout,
    output logic [WORD_W-1:0] b_half_dout,
    output logic [WORD_W-1:0] amb_half_dout,
    output logic [WORD_W-1:0] bma_half_dout,
    output logic              flag_carry,
    output logic              flag_borrow,
    output logic              flag_eq
);

    localparam int unsigned    K_W    = clog2(NUM_WORDS + 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_WORDS);

    state_e          state_q, state_d;
    logic [K_W-1:0]  k_q, k_d;
    logic            accept;

    logic            mode_q;
    logic            a_msb_q, b_msb_q;
    logic            nz_q;
    logic            flag_carry_q, flag_borrow_q, flag_eq_q;
    logic            fill_a_q, fill_b_q, fill_amb_q, fill_bma_q;

    logic [WORD_W-1:0] apb_res, amb_res, bma_res;
    logic              apb_co, amb_co, bma_co;

    assign accept = (state_q == ST_IDLE) && start;

    // FSM state and word counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next state; the counter restarts at zero on every state change.
    always_comb begin
        state_d = state_q;
        k_d     = '0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_P1;
            ST_P1: begin
                if (k_q == K_LAST) state_d = ST_P2;
                else               k_d     = k_q + 1'b1;
            end
            ST_P2: begin
                if (k_q == K_LAST) state_d = ST_DONE;
                else               k_d     = k_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and address decode from the registered state.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        rd_addr    = '0;
        p1_wren    = 1'b0;
        p1_wr_addr = '0;
        p2_wren    = 1'b0;
        p2_wr_addr = '0;
        case (state_q)
            ST_P1: begin
                busy = 1'b1;
                if (k_q != K_LAST) rd_addr = ADDR_W'(k_q);
                if (k_q != '0) begin
                    p1_wren    = 1'b1;
                    p1_wr_addr = ADDR_W'(k_q - 1'b1);
                end
            end
            ST_P2: begin
                busy = 1'b1;
                if (k_q != K_LAST) rd_addr = ADDR_W'(NUM_WORDS - 1) - ADDR_W'(k_q);
                if (k_q != '0) begin
                    p2_wren    = 1'b1;
                    p2_wr_addr = ADDR_W'(NUM_WORDS) - ADDR_W'(k_q);
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    modinv_precalc_addsub_word #(.WORD_W(WORD_W), .SUB(1'b0)) u_apb (
        .clk(clk), .rst(rst), .clr_i(accept), .en_i(p1_wren),
        .a_i(a_din), .b_i(b_din), .res_o(apb_res), .cb_o(apb_co)
    );

    modinv_precalc_addsub_word #(.WORD_W(WORD_W), .SUB(1'b1)) u_amb (
        .clk(clk), .rst(rst), .clr_i(accept), .en_i(p1_wren),
        .a_i(a_din), .b_i(b_din), .res_o(amb_res), .cb_o(amb_co)
    );

    modinv_precalc_addsub_word #(.WORD_W(WORD_W), .SUB(1'b1)) u_bma (
        .clk(clk), .rst(rst), .clr_i(accept), .en_i(p1_wren),
        .a_i(b_din), .b_i(a_din), .res_o(bma_res), .cb_o(bma_co)
    );

    // Pass-1 bookkeeping: doubling carries, zero tracking and end-of-pass flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= SHIFT_LOGICAL;
            a_msb_q       <= 1'b0;
            b_msb_q       <= 1'b0;
            nz_q          <= 1'b0;
            flag_carry_q  <= 1'b0;
            flag_borrow_q <= 1'b0;
            flag_eq_q     <= 1'b0;
        end else if (accept) begin
            mode_q        <= shift_mode;
            a_msb_q       <= 1'b0;
            b_msb_q       <= 1'b0;
            nz_q          <= 1'b0;
            flag_carry_q  <= 1'b0;
            flag_borrow_q <= 1'b0;
            flag_eq_q     <= 1'b0;
        end else if (p1_wren) begin
            a_msb_q <= a_din[WORD_W-1];
            b_msb_q <= b_din[WORD_W-1];
            nz_q    <= nz_q | (amb_res != '0);
            if (k_q == K_LAST) begin
                flag_carry_q  <= apb_co;
                flag_borrow_q <= amb_co;
                flag_eq_q     <= ~(nz_q | (amb_res != '0));
            end
        end
    end

    // Pass-2 fill bits: top-word fill loaded on the idle first P2 cycle,
    // then bit 0 of each word feeds the next lower word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_a_q   <= 1'b0;
            fill_b_q   <= 1'b0;
            fill_amb_q <= 1'b0;
            fill_bma_q <= 1'b0;
        end else if (state_q == ST_P2) begin
            if (k_q == '0) begin
                fill_a_q   <= 1'b0;
                fill_b_q   <= 1'b0;
                fill_amb_q <= (mode_q == SHIFT_ARITH) & flag_borrow_q;
                fill_bma_q <= (mode_q == SHIFT_ARITH) & ~flag_borrow_q & ~flag_eq_q;
            end else begin
                fill_a_q   <= a_din[0];
                fill_b_q   <= b_din[0];
                fill_amb_q <= amb_din[0];
                fill_bma_q <= bma_din[0];
            end
        end
    end

    // Result words, held at zero whenever the matching write enable is low.
    always_comb begin
        a_dbl_dout    = '0;
        b_dbl_dout    = '0;
        apb_dout      = '0;
        amb_dout      = '0;
        bma_dout      = '0;
        a_half_dout   = '0;
        b_half_dout   = '0;
        amb_half_dout = '0;
        bma_half_dout = '0;
        if (p1_wren) begin
            a_dbl_dout = {a_din[WORD_W-2:0], a_msb_q};
            b_dbl_dout = {b_din[WORD_W-2:0], b_msb_q};
            apb_dout   = apb_res;
            amb_dout   = amb_res;
            bma_dout   = bma_res;
        end
        if (p2_wren) begin
            a_half_dout   = {fill_a_q,   a_din[WORD_W-1:1]};
            b_half_dout   = {fill_b_q,   b_din[WORD_W-1:1]};
            amb_half_dout = {fill_amb_q, amb_din[WORD_W-1:1]};
            bma_half_dout = {fill_bma_q, bma_din[WORD_W-1:1]};
        end
    end

    assign flag_carry  = flag_carry_q;
    assign flag_borrow = flag_borrow_q;
    assign flag_eq     = flag_eq_q;

endmodule
